// File: rtl/emergency_request_ctrl_pkg.sv
// Shared definitions for the emergency request controller and its neighbours.
// Contents:
//   erc_state_t            FSM state encoding (ERC_IDLE/QUALIFY/FIRE/HOLDOFF)
//   LIGHT_* indices        bit positions within a light-output vector
//   EVENT_W / EVENT_MAX    width and ceiling of the maintenance event counter
//   sat_inc()              saturating increment for the event counter
package emergency_request_ctrl_pkg;

  typedef enum logic [1:0] {
    ERC_IDLE    = 2'd0,
    ERC_QUALIFY = 2'd1,
    ERC_FIRE    = 2'd2,
    ERC_HOLDOFF = 2'd3
  } erc_state_t;

  localparam int LIGHT_LEFT   = 3;
  localparam int LIGHT_GREEN  = 2;
  localparam int LIGHT_YELLOW = 1;
  localparam int LIGHT_RED    = 0;

  localparam int                EVENT_W   = 8;
  localparam logic [EVENT_W-1:0] EVENT_MAX = '1;

  // Maintenance counters stick at their ceiling instead of wrapping back to 0,
  // so a busy intersection never appears to have had no emergencies.
  function automatic logic [EVENT_W-1:0] sat_inc(input logic [EVENT_W-1:0] v);
    return (v == EVENT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/emergency_request_ctrl_if.sv
// Signal bundle between the sensor/maintenance side and the request controller.
//   sensor_raw   raw emergency sensor, asynchronous to clk
//   inhibit      synchronous suppress of new pulses (maintenance mode)
//   emergency    one-cycle pulse toward the light controllers
//   active       high while a pulse or its holdoff window is in progress
//   event_count  saturating count of pulses fired
// master: drives sensor_raw/inhibit and observes the rest.
// slave:  the controller itself.
interface emergency_request_ctrl_if;
  import emergency_request_ctrl_pkg::*;

  logic               sensor_raw;
  logic               inhibit;
  logic               emergency;
  logic               active;
  logic [EVENT_W-1:0] event_count;

  modport master (
    output sensor_raw,
    output inhibit,
    input  emergency,
    input  active,
    input  event_count
  );

  modport slave (
    input  sensor_raw,
    input  inhibit,
    output emergency,
    output active,
    output event_count
  );

endinterface

// File: rtl/emergency_request_ctrl_sync_2ff.sv
// sync_2ff: generic two-flop synchroniser for slow asynchronous inputs
// (emergency sensor today, pedestrian buttons later).
// Ports:
//   clk    destination clock, rising edge
//   rst_n  asynchronous active-low reset, clears both stages
//   d      asynchronous input vector
//   q      synchronised output, two clk edges behind d
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  // First stage may go metastable; the second stage gives it a full cycle
  // to resolve before anything downstream looks at the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/emergency_request_ctrl.sv
// emergency_request_ctrl: turns a raw emergency-vehicle sensor into clean,
// rate-limited one-cycle pulses for the trafficlightNS/EW emergency input.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of emergency_request_ctrl_if
//          (sensor_raw, inhibit in; emergency, active, event_count out)
// Parameters:
//   DEBOUNCE_CYCLES  synced-high samples needed before a pulse (>=1)
//   HOLDOFF_CYCLES   cycles after a pulse with no new pulse (>=2)
//   CNT_W            counter width, must hold max(DEBOUNCE, HOLDOFF)
module emergency_request_ctrl
  import emergency_request_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int CNT_W           = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  emergency_request_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLDOFF_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

  logic               s_sync;
  logic               request;
  erc_state_t         state;
  erc_state_t         next_state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               emergency_q;
  logic               active_q;
  logic [EVENT_W-1:0] event_count_q;

  sync_2ff #(.W(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.sensor_raw),
    .q     (s_sync)
  );

  // A request only counts when the synced sensor is high and maintenance
  // mode is off; inhibit is already in the clk domain.
  assign request = s_sync & ~bus.inhibit;

  // State and shared debounce/holdoff counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ERC_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. One counter serves both the debounce run in QUALIFY
  // and the holdoff window; FIRE always clears it on the way to HOLDOFF.
  // At the end of holdoff a still-present request re-fires immediately,
  // so a held sensor yields a steady pulse train without re-debouncing.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      ERC_IDLE: begin
        if (request) begin
          if (DEBOUNCE_CYCLES == 1) begin
            next_state = ERC_FIRE;
            cnt_next   = '0;
          end else begin
            next_state = ERC_QUALIFY;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      ERC_QUALIFY: begin
        if (!request) begin
          next_state = ERC_IDLE;
          cnt_next   = '0;
        end else if (cnt == DEBOUNCE_LAST) begin
          next_state = ERC_FIRE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ERC_FIRE: begin
        next_state = ERC_HOLDOFF;
        cnt_next   = '0;
      end
      ERC_HOLDOFF: begin
        if (cnt == HOLDOFF_LAST) begin
          next_state = request ? ERC_FIRE : ERC_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        next_state = ERC_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are flops loaded from next_state so they line up exactly with
  // the state register while staying glitch-free for the light controllers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emergency_q   <= 1'b0;
      active_q      <= 1'b0;
      event_count_q <= '0;
    end else begin
      emergency_q <= (next_state == ERC_FIRE);
      active_q    <= (next_state == ERC_FIRE) || (next_state == ERC_HOLDOFF);
      if (next_state == ERC_FIRE) begin
        event_count_q <= sat_inc(event_count_q);
      end
    end
  end

  assign bus.emergency   = emergency_q;
  assign bus.active      = active_q;
  assign bus.event_count = event_count_q;

endmodule

// File: tb/tb_emergency_request_ctrl.sv
// Scoreboard bench for emergency_request_ctrl. The stimulus side predicts
// each clock edge's outputs from pulse-timing rules and queues them; a
// monitor pops one expectation per edge and compares.
module tb_emergency_request_ctrl;
  import emergency_request_ctrl_pkg::*;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  typedef struct packed {
    logic       emergency;
    logic       active;
    logic [7:0] count;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  emergency_request_ctrl_if bus ();

  emergency_request_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLDOFF_CYCLES  (HOLD),
    .CNT_W           (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   checking = 0;

  // Reference model state: edge index, the last two sensor values seen
  // (sensor reaches the FSM two edges late), length of the current run of
  // qualifying samples, edge of the last pulse and total pulses.
  int   t          = 0;
  logic h1         = 1'b0;
  logic h2         = 1'b0;
  int   run        = 0;
  int   last_pulse = -1000;
  int   pulses     = 0;

  task automatic checkOutput(input string name, input exp_t e);
    exp_t a;
    a.emergency = bus.emergency;
    a.active    = bus.active;
    a.count     = bus.event_count;
    checks++;
    if (a !== e) begin
      failures++;
      $display("[TB] FAIL %s edge=%0d actual emergency=%b active=%b count=%0d required emergency=%b active=%b count=%0d",
               name, t, a.emergency, a.active, a.count, e.emergency, e.active, e.count);
    end
  endtask

  // Predict the outputs after the next rising edge.
  // A pulse fires when either exactly HOLD+1 edges have passed since the
  // last pulse and a request is present, or when DEB consecutive requests
  // have been seen entirely after the previous holdoff window closed.
  task automatic modelEdge(input logic rst, input logic sens, input logic inh);
    exp_t e;
    logic q;
    bit   fire;
    t++;
    e = '0;
    if (!rst) begin
      h1 = 1'b0; h2 = 1'b0; run = 0; last_pulse = -1000; pulses = 0;
    end else begin
      q  = h2 && !inh;
      h2 = h1;
      h1 = sens;
      run = q ? run + 1 : 0;
      fire = 0;
      if (t == last_pulse + HOLD + 1) fire = q;
      else if (t >= last_pulse + HOLD + 1 + DEB && run >= DEB) fire = 1;
      if (fire) begin
        last_pulse = t;
        if (pulses < 255) pulses++;
      end
      e.emergency = fire;
      e.active    = (t >= last_pulse) && (t <= last_pulse + HOLD);
      e.count     = 8'(pulses);
    end
    sb.push_back(e);
    checking = 1;
  endtask

  task automatic applyStimulus(input logic rst, input logic sens, input logic inh);
    @(negedge clk);
    rst_n          = rst;
    bus.sensor_raw = sens;
    bus.inhibit    = inh;
    modelEdge(rst, sens, inh);
  endtask

  task automatic repeatStimulus(input int n, input logic rst, input logic sens, input logic inh);
    for (int i = 0; i < n; i++) applyStimulus(rst, sens, inh);
  endtask

  // Drop reset well away from any edge and check outputs clear at once.
  task automatic asyncResetCheck(input string name);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(name, '0);
    modelEdge(1'b0, bus.sensor_raw, bus.inhibit);
  endtask

  // Monitor: one expectation per rising edge, sampled just after it.
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checkOutput("edge_outputs", mon_e);
      end else if (checking) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty edge=%0d actual queue=0 required queue>0", t);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bus.sensor_raw = 1'b1;
    bus.inhibit    = 1'b0;

    // Reset held with sensor high, then release and keep it high.
    repeatStimulus(5, 1'b0, 1'b1, 1'b0);
    repeatStimulus(12, 1'b1, 1'b1, 1'b0);
    repeatStimulus(15, 1'b1, 1'b0, 1'b0);

    // Glitch of 3 cycles: no pulse.
    repeatStimulus(3, 1'b1, 1'b1, 1'b0);
    repeatStimulus(12, 1'b1, 1'b0, 1'b0);

    // Single 10-cycle request.
    repeatStimulus(10, 1'b1, 1'b1, 1'b0);
    repeatStimulus(15, 1'b1, 1'b0, 1'b0);

    // Held sensor: pulse train.
    repeatStimulus(40, 1'b1, 1'b1, 1'b0);
    repeatStimulus(15, 1'b1, 1'b0, 1'b0);

    // Inhibit throughout a request, then inhibit raised during holdoff.
    repeatStimulus(20, 1'b1, 1'b1, 1'b1);
    repeatStimulus(10, 1'b1, 1'b0, 1'b0);
    repeatStimulus(12, 1'b1, 1'b1, 1'b0);
    repeatStimulus(12, 1'b1, 1'b1, 1'b1);
    repeatStimulus(10, 1'b1, 1'b0, 1'b0);

    // Async reset in the middle of holdoff.
    repeatStimulus(9, 1'b1, 1'b1, 1'b0);
    asyncResetCheck("async_reset_holdoff");
    repeatStimulus(3, 1'b0, 1'b0, 1'b0);
    repeatStimulus(5, 1'b1, 1'b0, 1'b0);

    // Randomised bursts with occasional inhibit.
    for (int b = 0; b < 100; b++) begin
      n = $urandom_range(1, 14);
      repeatStimulus(n, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
    end
    repeatStimulus(15, 1'b1, 1'b0, 1'b0);

    // Saturation: hold the sensor long enough for more than 255 pulses.
    repeatStimulus(256 * (HOLD + 1) + 20, 1'b1, 1'b1, 1'b0);

    // Async reset while the pulse itself is high.
    for (int i = 0; i < 20 && last_pulse != t; i++) applyStimulus(1'b1, 1'b1, 1'b0);
    if (last_pulse != t) begin
      checks++;
      failures++;
      $display("[TB] FAIL fire_wait actual=no_pulse required=pulse");
    end
    asyncResetCheck("async_reset_fire");
    repeatStimulus(3, 1'b0, 1'b0, 1'b0);
    repeatStimulus(10, 1'b1, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
